// File: rtl/bus_loader.sv
// Bank of COUNT registers loaded in parallel from a shared bus, with per-register
// freshness tracking, load statistics and floating-bus detection.
module bus_loader #(
  parameter int WIDTH       = 8,
  parameter int COUNT       = 8,
  parameter int TOTAL_WIDTH = WIDTH * COUNT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             bus_in,
  input  logic                         bus_driven,
  input  logic [COUNT-1:0]             load,
  input  logic [COUNT-1:0]             ack,
  input  logic                         err_clear,
  output logic [TOTAL_WIDTH-1:0]       out,
  output logic [COUNT-1:0]             fresh,
  output logic [$clog2(COUNT+1)-1:0]   last_loaded,
  output logic [15:0]                  load_count,
  output logic                         float_err
);

  localparam int          IDX_W     = $clog2(COUNT + 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic                   any_load;
  logic                   float_event;
  logic [WIDTH-1:0]       capture_value;
  logic [IDX_W-1:0]       high_idx;
  logic [WIDTH*COUNT-1:0] packed_data;

  logic [COUNT-1:0]       fresh_reg, fresh_next;
  logic [IDX_W-1:0]       last_loaded_reg, last_loaded_next;
  logic [15:0]            load_count_reg, load_count_next;
  logic                   float_err_reg, float_err_next;

  assign any_load    = |load;
  assign float_event = any_load & ~bus_driven;
  // An undriven bus is pulled high, so loads capture all-ones.
  assign capture_value = bus_driven ? bus_in : {WIDTH{1'b1}};

  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_reg
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] data_next;

      always_comb begin
        data_next = data_reg;
        if (load[gi]) begin
          data_next = capture_value;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          data_reg <= '0;
        end else begin
          data_reg <= data_next;
        end
      end

      assign packed_data[gi*WIDTH +: WIDTH] = data_reg;
    end
  endgenerate

  // Highest asserted load bit wins; loop order makes later indices override.
  always_comb begin
    high_idx = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (load[i]) begin
        high_idx = IDX_W'(i + 1);
      end
    end
  end

  always_comb begin
    // A load in the same cycle as an ack keeps the register fresh.
    fresh_next       = load | (fresh_reg & ~ack);
    last_loaded_next = any_load ? high_idx : last_loaded_reg;
    load_count_next  = load_count_reg;
    if (any_load && (load_count_reg != COUNT_MAX)) begin
      load_count_next = load_count_reg + 16'd1;
    end
    float_err_next = float_err_reg;
    if (float_event) begin
      float_err_next = 1'b1;
    end else if (err_clear) begin
      float_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fresh_reg       <= '0;
      last_loaded_reg <= '0;
      load_count_reg  <= '0;
      float_err_reg   <= 1'b0;
    end else begin
      fresh_reg       <= fresh_next;
      last_loaded_reg <= last_loaded_next;
      load_count_reg  <= load_count_next;
      float_err_reg   <= float_err_next;
    end
  end

  assign out         = TOTAL_WIDTH'(packed_data);
  assign fresh       = fresh_reg;
  assign last_loaded = last_loaded_reg;
  assign load_count  = load_count_reg;
  assign float_err   = float_err_reg;

endmodule

// File: tb/tb_bus_loader.sv
// Directed testbench for bus_loader: a behavioural model is checked on every
// cycle, plus literal expectations at the key points of each scenario.
module tb_bus_loader;

  localparam int W = 8;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  bus_in;
  logic          bus_driven;
  logic [N-1:0]  load;
  logic [N-1:0]  ack;
  logic          err_clear;
  logic [W*N-1:0] out_w;
  logic [N-1:0]  fresh_w;
  logic [3:0]    last_w;
  logic [15:0]   count_w;
  logic          err_w;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state
  logic [W-1:0] m_reg [N];
  logic [N-1:0] m_fresh;
  int           m_last;
  int           m_count;
  bit           m_err;

  bus_loader #(.WIDTH(W), .COUNT(N)) dut (
    .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .bus_driven(bus_driven),
    .load(load), .ack(ack), .err_clear(err_clear), .out(out_w),
    .fresh(fresh_w), .last_loaded(last_w), .load_count(count_w), .float_err(err_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_out();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = m_reg[i];
    return v;
  endfunction

  // Applies one clock edge's worth of the block's rules to the model.
  task automatic model_step();
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_fresh = '0; m_last = 0; m_count = 0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          m_reg[i] = bus_driven ? bus_in : 8'hFF;
          m_fresh[i] = 1'b1;
        end else if (ack[i]) begin
          m_fresh[i] = 1'b0;
        end
      end
      if (load != 0) begin
        m_last  = $clog2(int'(load) + 1);
        m_count = (m_count < 65535) ? m_count + 1 : 65535;
        if (!bus_driven) m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
      end else if (err_clear) begin
        m_err = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic rn, input logic [N-1:0] ld, input logic [W-1:0] b,
                       input logic drv, input logic [N-1:0] ak, input logic ec);
    reset_n = rn; load = ld; bus_in = b; bus_driven = drv; ack = ak; err_clear = ec;
    cycle();
    $display("txn rst_n=%b load=%h bus=%h drv=%b ack=%h clr=%b -> out=%h fresh=%h last=%0d cnt=%0d err=%b",
             rn, ld, b, drv, ak, ec, out_w, fresh_w, last_w, count_w, err_w);
  endtask

  // Compare process: DUT against model every cycle once reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      chk("out", 64'(out_w), model_out());
      chk("fresh", 64'(fresh_w), 64'(m_fresh));
      chk("last_loaded", 64'(last_w), 64'(m_last));
      chk("load_count", 64'(count_w), 64'(m_count));
      chk("float_err", 64'(err_w), 64'(m_err));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    m_fresh = '0; m_last = 0; m_count = 0; m_err = 1'b0;
    reset_n = 1'b0; load = '0; bus_in = '0; bus_driven = 1'b0; ack = '0; err_clear = 1'b0;

    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    check_en = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("reset_out", 64'(out_w), 64'h0);
    chk("reset_status", {32'h0, 8'(fresh_w), 4'(last_w), count_w, 3'b0, err_w}, 64'h0);

    // Single register load
    drive(1'b1, 8'h04, 8'hA5, 1'b1, 8'h00, 1'b0);
    chk("lit_one_out", 64'(out_w), 64'h0000_0000_00A5_0000);
    chk("lit_one_fresh", 64'(fresh_w), 64'h04);
    chk("lit_one_last", 64'(last_w), 64'd3);
    chk("lit_one_count", 64'(count_w), 64'd1);

    // Two registers in one cycle count once
    drive(1'b1, 8'h81, 8'h3C, 1'b1, 8'h00, 1'b0);
    chk("lit_two_out", 64'(out_w), 64'h3C00_0000_00A5_003C);
    chk("lit_two_last", 64'(last_w), 64'd8);
    chk("lit_two_count", 64'(count_w), 64'd2);

    // Floating bus and sticky error
    drive(1'b1, 8'h02, 8'h12, 1'b0, 8'h00, 1'b0);
    chk("lit_float_byte", 64'(out_w[15:8]), 64'hFF);
    chk("lit_float_err", 64'(err_w), 64'd1);
    drive(1'b1, 8'h00, 8'h55, 1'b1, 8'h00, 1'b1);
    chk("lit_clear_err", 64'(err_w), 64'd0);
    drive(1'b1, 8'h20, 8'h55, 1'b0, 8'h00, 1'b1);
    chk("lit_set_wins", 64'(err_w), 64'd1);
    drive(1'b1, 8'h00, 8'h99, 1'b1, 8'h00, 1'b0);
    chk("lit_noop_count", 64'(count_w), 64'd4);
    chk("lit_noop_err", 64'(err_w), 64'd1);

    // Ack against load, ack alone, ack on an idle bit
    drive(1'b1, 8'h04, 8'h5A, 1'b1, 8'h04, 1'b0);
    chk("lit_ackload_fresh", 64'(fresh_w[2]), 64'd1);
    chk("lit_ackload_byte", 64'(out_w[23:16]), 64'h5A);
    drive(1'b1, 8'h00, 8'h00, 1'b1, 8'h04, 1'b0);
    chk("lit_ack_fresh", 64'(fresh_w[2]), 64'd0);
    drive(1'b1, 8'h00, 8'h00, 1'b1, 8'h05, 1'b0);
    chk("lit_ack_idle", 64'(fresh_w), 64'hA2);

    // Reset beats a simultaneous full load; then the load behaves as from power-up
    drive(1'b0, 8'hFF, 8'h77, 1'b1, 8'h00, 1'b1);
    chk("lit_rst_out", 64'(out_w), 64'h0);
    chk("lit_rst_status", {32'h0, 8'(fresh_w), 4'(last_w), count_w, 3'b0, err_w}, 64'h0);
    drive(1'b1, 8'hFF, 8'h77, 1'b1, 8'h00, 1'b0);
    chk("lit_post_out", 64'(out_w), 64'h7777_7777_7777_7777);
    chk("lit_post_count", 64'(count_w), 64'd1);
    chk("lit_post_last", 64'(last_w), 64'd8);

    // Saturation: run the counter up to its maximum, then one more load
    $display("txn bulk: 65534 load cycles toward load_count saturation");
    for (int i = 0; i < 65534; i++) begin
      reset_n = 1'b1; load = 8'((i % 255) + 1); bus_in = 8'(i); bus_driven = 1'b1;
      ack = 8'(i * 7); err_clear = 1'b0;
      cycle();
    end
    chk("lit_sat_reach", 64'(count_w), 64'hFFFF);
    drive(1'b1, 8'h10, 8'hC3, 1'b1, 8'h00, 1'b0);
    chk("lit_sat_hold", 64'(count_w), 64'hFFFF);
    chk("lit_sat_last", 64'(last_w), 64'd5);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
